bram_tile_reader: RTL

Read-side initiator for a single-port-read block RAM whose read address is registered and whose read data is visible combinationally the cycle after the address is accepted. On a start pulse it sweeps a rectangular tile (num_rows × num_cols, row-strided) out of the RAM and presents the elements as a valid/ready stream with row and tile end markers. It sits between a matrix buffer RAM and the compute pipelines that consume matrix rows or tiles.

---
 rtl/bram_tile_reader.sv | 136 +++++++++++++
 1 files changed

// File: rtl/bram_tile_reader.sv
// Sweeps a row-strided rectangular tile out of a registered-address block RAM
// and presents it as a valid/ready stream with row and tile end markers.
module bram_tile_reader #(
    parameter int datawidth = 32,
    parameter int addrwidth = 8,
    parameter int dimwidth  = 8
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 start,
    input  logic [addrwidth-1:0] base_addr,
    input  logic [dimwidth-1:0]  num_rows,
    input  logic [dimwidth-1:0]  num_cols,
    input  logic [addrwidth-1:0] row_stride,
    output logic                 busy,
    output logic                 done,
    output logic [addrwidth-1:0] read_addr,
    output logic                 read_addr_valid,
    input  logic [datawidth-1:0] read_data,
    output logic [datawidth-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_row_last,
    output logic                 out_last
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t               state;
    state_t               state_next;
    logic [dimwidth-1:0]  rows_q;
    logic [dimwidth-1:0]  cols_q;
    logic [addrwidth-1:0] stride_q;
    logic [addrwidth-1:0] row_base;
    logic [dimwidth-1:0]  col;
    logic [dimwidth-1:0]  row;

    logic accept;
    logic empty_tile;
    logic col_end;
    logic row_end;
    logic issue;
    logic handshake;

    assign accept     = (state == IDLE) && start;
    assign empty_tile = (num_rows == '0) || (num_cols == '0);
    assign col_end    = (col == cols_q - dimwidth'(1));
    assign row_end    = (row == rows_q - dimwidth'(1));
    assign issue      = (state == RUN) && (!out_valid || out_ready);
    assign handshake  = out_valid && out_ready;

    assign read_addr       = row_base + addrwidth'(col);
    assign read_addr_valid = issue;
    assign out_data        = read_data;
    assign busy            = (state != IDLE);
    assign done            = (state == DONE);

    // An empty tile idles one cycle in DRAIN (out_valid is low there) so its
    // done pulse lands two cycles after the start, like every other tile end.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = empty_tile ? DRAIN : RUN;
                end
            end
            RUN: begin
                if (issue && col_end && row_end) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (!out_valid || (handshake && out_last)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            rows_q   <= '0;
            cols_q   <= '0;
            stride_q <= '0;
            row_base <= '0;
            col      <= '0;
            row      <= '0;
        end else if (accept) begin
            rows_q   <= num_rows;
            cols_q   <= num_cols;
            stride_q <= row_stride;
            row_base <= base_addr;
            col      <= '0;
            row      <= '0;
        end else if (issue) begin
            if (col_end) begin
                col      <= '0;
                row      <= row + dimwidth'(1);
                row_base <= row_base + stride_q;
            end else begin
                col <= col + dimwidth'(1);
            end
        end
    end

    // Markers travel with the issued address so they line up with read_data.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            out_valid    <= 1'b0;
            out_row_last <= 1'b0;
            out_last     <= 1'b0;
        end else if (issue) begin
            out_valid    <= 1'b1;
            out_row_last <= col_end;
            out_last     <= col_end && row_end;
        end else if (handshake) begin
            out_valid <= 1'b0;
        end
    end

endmodule
